// File: rtl/dp_tile_source_pkg.sv
// Shared geometry, control/status bundles and FSM encoding for the tile source.
package dp_tile_source_pkg;

    localparam int RRAM_DOTP_HEIGHT = 16;
    localparam int RRAM_DOTP_WIDTH  = 16;
    localparam int WORD_SIZE        = 32;
    localparam int WORD_SIZE_MATRIX = 8;
    localparam int DATA_WIDTH       = 32;

    localparam int MAT_ELEMS_PER_BEAT = DATA_WIDTH / WORD_SIZE_MATRIX;
    localparam int VEC_ELEMS_PER_BEAT = DATA_WIDTH / WORD_SIZE;

    // One matrix row occupies a fixed number of beat slots regardless of the active width.
    localparam int MAT_ROW_BEATS = RRAM_DOTP_WIDTH / MAT_ELEMS_PER_BEAT;
    localparam int MAT_DEPTH     = RRAM_DOTP_HEIGHT * MAT_ROW_BEATS;
    localparam int VEC_DEPTH     = RRAM_DOTP_HEIGHT / VEC_ELEMS_PER_BEAT;
    localparam int MAT_AW        = $clog2(MAT_DEPTH);
    localparam int VEC_AW        = $clog2(VEC_DEPTH);

    typedef struct packed {
        logic       start;
        logic       clear;
        logic [7:0] w;
        logic [7:0] h;
    } dp_src_ctrl_t;

    typedef struct packed {
        logic busy;
        logic done;
    } dp_src_flags_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dp_src_state_e;

    // Oversized requests are served as the largest tile the buffers can hold.
    function automatic logic [7:0] clamp_dim(input logic [7:0] dim, input logic [7:0] max_dim);
        return (dim > max_dim) ? max_dim : dim;
    endfunction

endpackage

// File: rtl/dp_tile_source_beat_gen.sv
// One outgoing stream: walks a (row, col) element index, fetches each beat from the
// owning buffer one cycle ahead, zero-pads lanes past the active width and flags the end.
module dp_tile_source_beat_gen #(
    parameter int ELEMS     = 4,
    parameter int ES        = 8,
    parameter int DW        = 32,
    parameter int ROW_BEATS = 4,
    parameter int AW        = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          clear_i,
    input  logic [7:0]    n_rows_i,
    input  logic [7:0]    n_cols_i,
    input  logic          ready_i,
    input  logic [DW-1:0] rdata_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_o,
    output logic          last_hs_o,
    output logic          fin_o
);

    logic [7:0] row_q, row_d, col_q, col_d;
    logic [7:0] rows_q, rows_d, cols_q, cols_d;
    logic       valid_q, valid_d, fin_q, fin_d;
    logic       hs, col_more, row_more, is_last;

    function automatic logic [AW-1:0] beat_addr(input logic [7:0] row, input logic [7:0] col);
        return AW'(16'(row) * 16'(ROW_BEATS) + 16'(col / 8'(ELEMS)));
    endfunction

    // Position of the current beat within the active tile.
    always_comb begin
        hs       = valid_q & ready_i;
        col_more = (9'(col_q) + 9'(ELEMS)) < 9'(cols_q);
        row_more = (9'(row_q) + 9'd1) < 9'(rows_q);
        is_last  = !col_more && !row_more;
    end

    // Index advance; the buffer read for the next beat is issued in the handshake cycle.
    always_comb begin
        row_d     = row_q;
        col_d     = col_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        valid_d   = valid_q;
        fin_d     = fin_q;
        rd_en_o   = 1'b0;
        rd_addr_o = beat_addr(row_q, col_q);
        if (clear_i) begin
            row_d   = 8'd0;
            col_d   = 8'd0;
            valid_d = 1'b0;
            fin_d   = 1'b0;
        end else if (start_i) begin
            rows_d    = n_rows_i;
            cols_d    = n_cols_i;
            row_d     = 8'd0;
            col_d     = 8'd0;
            valid_d   = 1'b1;
            fin_d     = 1'b0;
            rd_en_o   = 1'b1;
            rd_addr_o = '0;
        end else if (hs) begin
            if (is_last) begin
                valid_d = 1'b0;
                fin_d   = 1'b1;
            end else begin
                if (col_more) begin
                    col_d = col_q + 8'(ELEMS);
                end else begin
                    col_d = 8'd0;
                    row_d = row_q + 8'd1;
                end
                rd_en_o   = 1'b1;
                rd_addr_o = beat_addr(row_d, col_d);
            end
        end
    end

    // Index, dimension and valid/finished registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_q   <= 8'd0;
            col_q   <= 8'd0;
            rows_q  <= 8'd0;
            cols_q  <= 8'd0;
            valid_q <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            valid_q <= valid_d;
            fin_q   <= fin_d;
        end
    end

    // Lanes beyond the active width read as zero; with cols cleared on reset the whole beat is zero.
    genvar gi;
    generate
        for (gi = 0; gi < ELEMS; gi++) begin : g_lane
            logic lane_on;
            assign lane_on = (9'(col_q) + 9'(gi)) < 9'(cols_q);
            assign data_o[gi*ES +: ES] = lane_on ? rdata_i[gi*ES +: ES] : '0;
        end
    endgenerate

    assign valid_o   = valid_q;
    assign last_hs_o = hs & is_last;
    assign fin_o     = fin_q;

endmodule

// File: rtl/dp_tile_source.sv
// Tile source: matrix and vector buffers loaded beat by beat, replayed as two
// independent valid/ready streams in the order the dot-product engine consumes them.
module dp_tile_source
    import dp_tile_source_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    ld_we_i,
    input  logic                    ld_sel_i,
    input  logic [7:0]              ld_addr_i,
    input  logic [DATA_WIDTH-1:0]   ld_data_i,
    input  logic                    start_i,
    input  logic                    clear_i,
    input  logic [7:0]              sub_mat_width_i,
    input  logic [7:0]              sub_mat_height_i,
    output logic                    mat_valid_o,
    input  logic                    mat_ready_i,
    output logic [DATA_WIDTH-1:0]   mat_data_o,
    output logic [DATA_WIDTH/8-1:0] mat_strb_o,
    output logic                    vec_valid_o,
    input  logic                    vec_ready_i,
    output logic [DATA_WIDTH-1:0]   vec_data_o,
    output logic [DATA_WIDTH/8-1:0] vec_strb_o,
    output logic                    busy_o,
    output logic                    done_o
);

    dp_src_ctrl_t  ctrl;
    dp_src_flags_t flags;
    dp_src_state_e state_q, state_d;

    logic [7:0]            w_clamped, h_clamped;
    logic                  zero_dim, gen_start, both_fin;
    logic                  mat_rd_en, vec_rd_en;
    logic [MAT_AW-1:0]     mat_rd_addr;
    logic [VEC_AW-1:0]     vec_rd_addr;
    logic                  mat_last_hs, vec_last_hs, mat_fin, vec_fin;
    logic [DATA_WIDTH-1:0] mat_rdata_q, vec_rdata_q;
    logic [DATA_WIDTH-1:0] mat_mem [MAT_DEPTH];
    logic [DATA_WIDTH-1:0] vec_mem [VEC_DEPTH];

    assign ctrl      = '{start: start_i, clear: clear_i, w: sub_mat_width_i, h: sub_mat_height_i};
    assign w_clamped = clamp_dim(ctrl.w, 8'(RRAM_DOTP_WIDTH));
    assign h_clamped = clamp_dim(ctrl.h, 8'(RRAM_DOTP_HEIGHT));
    assign zero_dim  = (w_clamped == 8'd0) || (h_clamped == 8'd0);
    // A stream counts as finished already in its final handshake cycle so done lands one cycle later.
    assign both_fin  = (mat_fin | mat_last_hs) & (vec_fin | vec_last_hs);

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state; clear overrides everything, a start while sending is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (ctrl.start) state_d = zero_dim ? DONE : SEND;
            SEND:       if (both_fin)   state_d = DONE;
            default:    state_d = IDLE;
        endcase
        if (ctrl.clear) state_d = IDLE;
    end

    // FSM outputs.
    always_comb begin
        flags.busy = (state_q == SEND);
        flags.done = (state_q == DONE);
        gen_start  = ctrl.start && !ctrl.clear && (state_q != SEND) && !zero_dim;
    end

    // Matrix buffer: loads are dropped while replaying; registered read feeds the stream.
    always_ff @(posedge clk_i) begin
        if (ld_we_i && !ld_sel_i && !flags.busy && (ld_addr_i < 8'(MAT_DEPTH)))
            mat_mem[ld_addr_i[MAT_AW-1:0]] <= ld_data_i;
        if (mat_rd_en)
            mat_rdata_q <= mat_mem[mat_rd_addr];
    end

    // Vector buffer: same load rules as the matrix buffer.
    always_ff @(posedge clk_i) begin
        if (ld_we_i && ld_sel_i && !flags.busy && (ld_addr_i < 8'(VEC_DEPTH)))
            vec_mem[ld_addr_i[VEC_AW-1:0]] <= ld_data_i;
        if (vec_rd_en)
            vec_rdata_q <= vec_mem[vec_rd_addr];
    end

    dp_tile_source_beat_gen #(
        .ELEMS(MAT_ELEMS_PER_BEAT), .ES(WORD_SIZE_MATRIX), .DW(DATA_WIDTH),
        .ROW_BEATS(MAT_ROW_BEATS), .AW(MAT_AW)
    ) u_mat_gen (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(gen_start), .clear_i(ctrl.clear),
        .n_rows_i(h_clamped), .n_cols_i(w_clamped), .ready_i(mat_ready_i),
        .rdata_i(mat_rdata_q), .valid_o(mat_valid_o), .data_o(mat_data_o),
        .rd_en_o(mat_rd_en), .rd_addr_o(mat_rd_addr), .last_hs_o(mat_last_hs), .fin_o(mat_fin)
    );

    // The vector is a single row whose length is the tile height.
    dp_tile_source_beat_gen #(
        .ELEMS(VEC_ELEMS_PER_BEAT), .ES(WORD_SIZE), .DW(DATA_WIDTH),
        .ROW_BEATS(1), .AW(VEC_AW)
    ) u_vec_gen (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(gen_start), .clear_i(ctrl.clear),
        .n_rows_i(8'd1), .n_cols_i(h_clamped), .ready_i(vec_ready_i),
        .rdata_i(vec_rdata_q), .valid_o(vec_valid_o), .data_o(vec_data_o),
        .rd_en_o(vec_rd_en), .rd_addr_o(vec_rd_addr), .last_hs_o(vec_last_hs), .fin_o(vec_fin)
    );

    assign mat_strb_o = '1;
    assign vec_strb_o = '1;
    assign busy_o     = flags.busy;
    assign done_o     = flags.done;

endmodule

// File: tb/tb_dp_tile_source.sv
// Scoreboard bench for dp_tile_source: expected beats come from a loop model of the
// tile replay order; per-stream monitors pop and compare on every handshake.
module tb_dp_tile_source;

    logic        clk_i = 1'b0;
    logic        rst_i, ld_we_i, ld_sel_i, start_i, clear_i;
    logic [7:0]  ld_addr_i, sub_mat_width_i, sub_mat_height_i;
    logic [31:0] ld_data_i;
    logic        mat_valid_o, mat_ready_i, vec_valid_o, vec_ready_i;
    logic [31:0] mat_data_o, vec_data_o;
    logic [3:0]  mat_strb_o, vec_strb_o;
    logic        busy_o, done_o;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          mat_rand = 1'b0;
    bit          vec_rand = 1'b0;
    bit          mat_hold = 1'b0;
    bit          vec_hold = 1'b0;
    logic [31:0] mat_hold_data, vec_hold_data;
    logic [7:0]  tb_mat [16][16];
    logic [31:0] tb_vec [16];
    logic [31:0] exp_mat_q [$];
    logic [31:0] exp_vec_q [$];

    always #5 clk_i = ~clk_i;

    dp_tile_source dut (
        .clk_i(clk_i), .rst_i(rst_i), .ld_we_i(ld_we_i), .ld_sel_i(ld_sel_i),
        .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i), .start_i(start_i), .clear_i(clear_i),
        .sub_mat_width_i(sub_mat_width_i), .sub_mat_height_i(sub_mat_height_i),
        .mat_valid_o(mat_valid_o), .mat_ready_i(mat_ready_i), .mat_data_o(mat_data_o),
        .mat_strb_o(mat_strb_o), .vec_valid_o(vec_valid_o), .vec_ready_i(vec_ready_i),
        .vec_data_o(vec_data_o), .vec_strb_o(vec_strb_o), .busy_o(busy_o), .done_o(done_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: matrix row-major in groups of 4 columns, vector one element per beat.
    task automatic push_expected(input int w, input int h);
        int wc = (w > 16) ? 16 : w;
        int hc = (h > 16) ? 16 : h;
        logic [31:0] beat;
        if (wc == 0 || hc == 0) return;
        for (int r = 0; r < hc; r++) begin
            for (int c = 0; c < wc; c += 4) begin
                beat = '0;
                for (int i = 0; i < 4; i++)
                    if (c + i < wc) beat[8*i +: 8] = tb_mat[r][c+i];
                exp_mat_q.push_back(beat);
            end
        end
        for (int i = 0; i < hc; i++) exp_vec_q.push_back(tb_vec[i]);
    endtask

    task automatic load_buffers(input bit pattern);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                tb_mat[r][c] = pattern ? 8'(r * 16 + c) : 8'($urandom);
        for (int i = 0; i < 16; i++) tb_vec[i] = pattern ? 32'(i + 1) : $urandom;
        for (int a = 0; a < 64; a++) begin
            @(negedge clk_i);
            ld_we_i = 1'b1; ld_sel_i = 1'b0; ld_addr_i = 8'(a);
            ld_data_i = {tb_mat[a/4][(a%4)*4+3], tb_mat[a/4][(a%4)*4+2],
                         tb_mat[a/4][(a%4)*4+1], tb_mat[a/4][(a%4)*4]};
        end
        for (int a = 0; a < 16; a++) begin
            @(negedge clk_i);
            ld_we_i = 1'b1; ld_sel_i = 1'b1; ld_addr_i = 8'(a); ld_data_i = tb_vec[a];
        end
        @(negedge clk_i);
        ld_we_i = 1'b0;
    endtask

    task automatic start_tile(input int w, input int h);
        int wc = (w > 16) ? 16 : w;
        int hc = (h > 16) ? 16 : h;
        push_expected(w, h);
        @(negedge clk_i);
        sub_mat_width_i = 8'(w); sub_mat_height_i = 8'(h); start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        cyc = 1;
        if (wc > 0 && hc > 0) begin
            check("busy_first_cycle", 32'(busy_o), 32'd1);
            check("mat_valid_first_cycle", 32'(mat_valid_o), 32'd1);
            check("vec_valid_first_cycle", 32'(vec_valid_o), 32'd1);
            check("done_cleared_by_start", 32'(done_o), 32'd0);
        end else begin
            check("zero_dim_done", 32'(done_o), 32'd1);
            check("zero_dim_busy", 32'(busy_o), 32'd0);
            check("zero_dim_mat_valid", 32'(mat_valid_o), 32'd0);
        end
    endtask

    task automatic wait_done(input string name, input int exp_cyc);
        while (done_o !== 1'b1 && cyc < 3000) begin
            @(negedge clk_i);
            cyc++;
        end
        check({name, "_done"}, 32'(done_o), 32'd1);
        if (exp_cyc > 0) check({name, "_latency"}, 32'(cyc), 32'(exp_cyc));
        check({name, "_mat_left"}, 32'(exp_mat_q.size()), 32'd0);
        check({name, "_vec_left"}, 32'(exp_vec_q.size()), 32'd0);
        $display("tile %s: done seen at cycle %0d", name, cyc);
    endtask

    // Matrix monitor: drives ready, checks stall stability and every accepted beat.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk_i);
            mat_ready_i = mat_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (mat_hold) begin
                total++;
                if (!mat_valid_o || mat_data_o !== mat_hold_data) begin
                    bad++;
                    $display("FAIL mat_stall_stable: got v=%0b d=%h, expected v=1 d=%h",
                             mat_valid_o, mat_data_o, mat_hold_data);
                end
            end
            mat_hold = 1'b0;
            if (mat_valid_o && mat_ready_i) begin
                total++;
                if (exp_mat_q.size() == 0) begin
                    bad++;
                    $display("FAIL mat_extra_beat: got %h, expected no beat", mat_data_o);
                end else begin
                    e = exp_mat_q.pop_front();
                    if (mat_data_o !== e) begin
                        bad++;
                        $display("FAIL mat_beat: got %h, expected %h", mat_data_o, e);
                    end
                end
            end else if (mat_valid_o) begin
                mat_hold = 1'b1;
                mat_hold_data = mat_data_o;
            end
        end
    end

    // Vector monitor: same checks on the vector stream.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk_i);
            vec_ready_i = vec_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (vec_hold) begin
                total++;
                if (!vec_valid_o || vec_data_o !== vec_hold_data) begin
                    bad++;
                    $display("FAIL vec_stall_stable: got v=%0b d=%h, expected v=1 d=%h",
                             vec_valid_o, vec_data_o, vec_hold_data);
                end
            end
            vec_hold = 1'b0;
            if (vec_valid_o && vec_ready_i) begin
                total++;
                if (exp_vec_q.size() == 0) begin
                    bad++;
                    $display("FAIL vec_extra_beat: got %h, expected no beat", vec_data_o);
                end else begin
                    e = exp_vec_q.pop_front();
                    if (vec_data_o !== e) begin
                        bad++;
                        $display("FAIL vec_beat: got %h, expected %h", vec_data_o, e);
                    end
                end
            end else if (vec_valid_o) begin
                vec_hold = 1'b1;
                vec_hold_data = vec_data_o;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, h;
        rst_i = 1'b1; ld_we_i = 1'b0; ld_sel_i = 1'b0; ld_addr_i = '0; ld_data_i = '0;
        start_i = 1'b0; clear_i = 1'b0; sub_mat_width_i = '0; sub_mat_height_i = '0;
        mat_ready_i = 1'b1; vec_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("rst_mat_valid", 32'(mat_valid_o), 32'd0);
        check("rst_vec_valid", 32'(vec_valid_o), 32'd0);
        check("rst_mat_data", mat_data_o, 32'd0);
        check("rst_vec_data", vec_data_o, 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("mat_strb", 32'(mat_strb_o), 32'hf);
        check("vec_strb", 32'(vec_strb_o), 32'hf);
        rst_i = 1'b0;

        // Full tile, pattern r*16+c, continuous ready.
        load_buffers(1'b1);
        start_tile(16, 16);
        wait_done("full_16x16", 65);

        // Partial tile with padded lanes.
        start_tile(6, 3);
        wait_done("w6_h3", 7);

        // Random stalls on the matrix stream only.
        mat_rand = 1'b1;
        start_tile(16, 16);
        wait_done("mat_stall", -1);
        mat_rand = 1'b0;

        // Clear while beat 10 is on the wire, then a clean replay.
        start_tile(16, 16);
        repeat (10) @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        check("clear_mat_valid", 32'(mat_valid_o), 32'd0);
        check("clear_vec_valid", 32'(vec_valid_o), 32'd0);
        check("clear_busy", 32'(busy_o), 32'd0);
        check("clear_done", 32'(done_o), 32'd0);
        exp_mat_q.delete();
        exp_vec_q.delete();
        start_tile(16, 16);
        wait_done("after_clear", 65);

        // Zero width, then start and load during a replay must have no effect.
        start_tile(0, 5);
        wait_done("zero_w", 1);
        start_tile(4, 4);
        @(negedge clk_i);
        cyc++;
        sub_mat_width_i = 8'd16; sub_mat_height_i = 8'd16; start_i = 1'b1;
        ld_we_i = 1'b1; ld_sel_i = 1'b0; ld_addr_i = 8'd0; ld_data_i = 32'hdeadbeef;
        @(negedge clk_i);
        cyc++;
        start_i = 1'b0; ld_we_i = 1'b0;
        wait_done("start_ignored", 5);
        start_tile(4, 4);
        wait_done("load_dropped", 5);

        // Reset in the middle of a replay.
        start_tile(16, 16);
        repeat (5) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("midrst_mat_valid", 32'(mat_valid_o), 32'd0);
        check("midrst_vec_valid", 32'(vec_valid_o), 32'd0);
        check("midrst_mat_data", mat_data_o, 32'd0);
        check("midrst_vec_data", vec_data_o, 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        exp_mat_q.delete();
        exp_vec_q.delete();

        // Random contents, dimensions (including clamped and zero) and backpressure.
        for (int t = 0; t < 6; t++) begin
            load_buffers(1'b0);
            w = $urandom_range(0, 20);
            h = $urandom_range(0, 20);
            mat_rand = ($urandom_range(0, 1) == 1);
            vec_rand = ($urandom_range(0, 1) == 1);
            start_tile(w, h);
            wait_done($sformatf("rand_w%0d_h%0d", w, h), (w == 0 || h == 0) ? 1 : -1);
        end
        mat_rand = 1'b0;
        vec_rand = 1'b0;
        repeat (3) @(negedge clk_i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
